// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and write-arbiter state encoding.
package regfile_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 8;
    localparam int NUM_REGS   = 8;
    typedef enum logic {MEM_PRI, ALU_FORCE} arb_state_t;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: counts consecutive ALU denials, saturating at STARVE_LIMIT.
module starve_counter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic alu_valid,
    input  logic alu_ready,
    output logic reach
);
    logic [2:0] count, count_next;
    always_comb begin
        count_next = (alu_ready || !alu_valid) ? 3'd0 :
                     (count >= 3'(STARVE_LIMIT)) ? count : count + 3'd1;
        reach = count_next == 3'(STARVE_LIMIT);
    end
    always_ff @(posedge CLK) count <= RESET ? 3'd0 : count_next;
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: arbitrates MEM/ALU writebacks onto the single register-file
// write port and tracks pending destination registers in a BUSY scoreboard.
module reg_write_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  MEM_VALID,
    input  logic [REG_ADDR_W-1:0] MEM_ADDR,
    input  logic [REG_DATA_W-1:0] MEM_DATA,
    output logic                  MEM_READY,
    input  logic                  ALU_VALID,
    input  logic [REG_ADDR_W-1:0] ALU_ADDR,
    input  logic [REG_DATA_W-1:0] ALU_DATA,
    output logic                  ALU_READY,
    input  logic                  ISSUE_VALID,
    input  logic [REG_ADDR_W-1:0] ISSUE_ADDR,
    output logic                  RF_WRITE,
    output logic [REG_ADDR_W-1:0] RF_INADDRESS,
    output logic [REG_DATA_W-1:0] RF_IN,
    output logic [NUM_REGS-1:0]   BUSY
);
    arb_state_t state;
    logic reach, mem_pri, grant;
    logic [NUM_REGS-1:0] set_mask, clr_mask;
    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .CLK(CLK), .RESET(RESET), .alu_valid(ALU_VALID), .alu_ready(ALU_READY), .reach(reach)
    );
    always_comb begin
        mem_pri   = state == MEM_PRI;
        MEM_READY = !RESET && MEM_VALID && (!ALU_VALID || mem_pri);
        ALU_READY = !RESET && ALU_VALID && (!MEM_VALID || !mem_pri);
        grant     = MEM_READY || ALU_READY;
        set_mask  = ISSUE_VALID ? NUM_REGS'(1) << ISSUE_ADDR : '0;
        clr_mask  = RF_WRITE ? NUM_REGS'(1) << RF_INADDRESS : '0;
    end
    // Set is OR'd after clear so a same-cycle issue keeps the register busy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= MEM_PRI;
            RF_WRITE     <= 1'b0;
            RF_INADDRESS <= '0;
            RF_IN        <= '0;
            BUSY         <= '0;
        end else begin
            state    <= mem_pri ? (reach ? ALU_FORCE : MEM_PRI)
                                : ((ALU_READY || !ALU_VALID) ? MEM_PRI : ALU_FORCE);
            RF_WRITE <= grant;
            if (grant) begin
                RF_INADDRESS <= MEM_READY ? MEM_ADDR : ALU_ADDR;
                RF_IN        <= MEM_READY ? MEM_DATA : ALU_DATA;
            end
            BUSY <= (BUSY & ~clr_mask) | set_mask;
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed vector table plus hand sequences for reset,
// starvation and mid-operation reset.
module tb_reg_write_arbiter;
    logic CLK = 1'b0, RESET = 1'b1;
    logic MEM_VALID = 1'b0, ALU_VALID = 1'b0, ISSUE_VALID = 1'b0;
    logic [2:0] MEM_ADDR = '0, ALU_ADDR = '0, ISSUE_ADDR = '0;
    logic [7:0] MEM_DATA = '0, ALU_DATA = '0;
    logic MEM_READY, ALU_READY, RF_WRITE;
    logic [2:0] RF_INADDRESS;
    logic [7:0] RF_IN, BUSY;
    int total = 0, bad = 0;

    reg_write_arbiter #(.STARVE_LIMIT(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
        .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR),
        .RF_WRITE(RF_WRITE), .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic mv; logic [2:0] ma; logic [7:0] md;
        logic av; logic [2:0] aa; logic [7:0] ad;
        logic iv; logic [2:0] ia;
        logic emr, ear, ew; logic [2:0] ea; logic [7:0] ed, eb;
    } vec_t;
    vec_t v [23];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [2:0] ma, input logic [7:0] md,
                         input logic av, input logic [2:0] aa, input logic [7:0] ad,
                         input logic iv, input logic [2:0] ia);
        MEM_VALID = mv; MEM_ADDR = ma; MEM_DATA = md;
        ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
        ISSUE_VALID = iv; ISSUE_ADDR = ia;
    endtask

    initial begin
        // registered expectations (ew/ea/ed/eb) reflect the rows before each row
        v[0]  = '{0,0,8'h00, 1,5,8'hA5, 0,0, 0,1, 0,0,8'h00,8'h00};
        v[1]  = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 1,5,8'hA5,8'h00};
        v[2]  = '{0,0,8'h00, 0,0,8'h00, 1,2, 0,0, 0,5,8'hA5,8'h00};
        v[3]  = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,5,8'hA5,8'h04};
        v[4]  = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,5,8'hA5,8'h04};
        v[5]  = '{1,2,8'h3C, 0,0,8'h00, 0,0, 1,0, 0,5,8'hA5,8'h04};
        v[6]  = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 1,2,8'h3C,8'h04};
        v[7]  = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,2,8'h3C,8'h00};
        v[8]  = '{0,0,8'h00, 0,0,8'h00, 1,3, 0,0, 0,2,8'h3C,8'h00};
        v[9]  = '{1,3,8'h11, 0,0,8'h00, 0,0, 1,0, 0,2,8'h3C,8'h08};
        v[10] = '{0,0,8'h00, 0,0,8'h00, 1,3, 0,0, 1,3,8'h11,8'h08};
        v[11] = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,3,8'h11,8'h08};
        v[12] = '{1,6,8'h66, 1,6,8'h77, 0,0, 1,0, 0,3,8'h11,8'h08};
        v[13] = '{0,0,8'h00, 1,6,8'h77, 0,0, 0,1, 1,6,8'h66,8'h08};
        v[14] = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 1,6,8'h77,8'h08};
        v[15] = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,6,8'h77,8'h08};
        v[16] = '{1,1,8'h01, 1,2,8'h02, 0,0, 1,0, 0,6,8'h77,8'h08};
        v[17] = '{1,1,8'h01, 1,2,8'h02, 0,0, 1,0, 1,1,8'h01,8'h08};
        v[18] = '{1,1,8'h01, 1,2,8'h02, 0,0, 1,0, 1,1,8'h01,8'h08};
        v[19] = '{1,1,8'h09, 0,0,8'h00, 0,0, 1,0, 1,1,8'h01,8'h08};
        v[20] = '{1,1,8'h0A, 1,2,8'h02, 0,0, 1,0, 1,1,8'h09,8'h08};
        v[21] = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 1,1,8'h0A,8'h08};
        v[22] = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,1,8'h0A,8'h08};

        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            RESET = 1'b1;
            drive(1, 1, 8'h55, 1, 2, 8'h66, 1, 1);
            #1;
            check("rst_mem_ready", i, MEM_READY, 0);
            check("rst_alu_ready", i, ALU_READY, 0);
            check("rst_rf_write", i, RF_WRITE, 0);
            check("rst_rf_addr", i, RF_INADDRESS, 0);
            check("rst_rf_in", i, RF_IN, 0);
            check("rst_busy", i, BUSY, 0);
        end

        for (int i = 0; i < 23; i++) begin
            @(negedge CLK);
            RESET = 1'b0;
            drive(v[i].mv, v[i].ma, v[i].md, v[i].av, v[i].aa, v[i].ad, v[i].iv, v[i].ia);
            #1;
            check("mem_ready", i, MEM_READY, v[i].emr);
            check("alu_ready", i, ALU_READY, v[i].ear);
            check("rf_write", i, RF_WRITE, v[i].ew);
            check("rf_addr", i, RF_INADDRESS, v[i].ea);
            check("rf_in", i, RF_IN, v[i].ed);
            check("busy", i, BUSY, v[i].eb);
        end

        // continuous contention: M,M,M,A repeating
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            drive(1, 1, 8'(i), 1, 2, 8'h80 | 8'(i), 0, 0);
            #1;
            check("starve_mem", i, MEM_READY, (i % 4) != 3);
            check("starve_alu", i, ALU_READY, (i % 4) == 3);
            if (i > 0) begin
                check("starve_rfw", i, RF_WRITE, 1);
                check("starve_rfin", i, RF_IN, ((i - 1) % 4 == 3) ? (8'h80 | 8'(i - 1)) : 8'(i - 1));
            end
        end
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("starve_last", 8, RF_IN, 8'h87);
        check("starve_last_addr", 8, RF_INADDRESS, 2);

        // prime the counter to 2, then reset during a would-be grant
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            drive(1, 4, 8'h40, 1, 5, 8'h50, 0, 0);
        end
        @(negedge CLK);
        RESET = 1'b1;
        drive(1, 7, 8'hFF, 1, 5, 8'h50, 0, 0);
        #1;
        check("midrst_mem_ready", 0, MEM_READY, 0);
        check("midrst_alu_ready", 0, ALU_READY, 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            RESET = 1'b0;
            drive(1, 4, 8'h40, 1, 5, 8'h50, 0, 0);
            #1;
            if (j == 0) begin
                check("midrst_rfw", j, RF_WRITE, 0);
                check("midrst_busy", j, BUSY, 0);
                check("midrst_rfin", j, RF_IN, 0);
            end
            check("midrst_mem", j, MEM_READY, j != 3);
            check("midrst_alu", j, ALU_READY, j == 3);
        end
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("midrst_final", 0, RF_IN, 8'h50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
